// File: rtl/mvau_stream_hs_if.sv
// mvau_stream_hs_if: activation, weight and result streams with valid/ready handshakes
interface mvau_stream_hs_if #(
  parameter int SIMD = 2,
  parameter int PE   = 2,
  parameter int TA   = 4,
  parameter int TW   = 4,
  parameter int TACC = 16
);
  logic [SIMD*TA-1:0]    in_act;
  logic                  in_act_v;
  logic                  in_act_rdy;
  logic [PE*SIMD*TW-1:0] in_wgt;
  logic                  in_wgt_v;
  logic                  in_wgt_rdy;
  logic [PE*TACC-1:0]    out;
  logic                  out_v;
  logic                  out_rdy;
  modport master (
    output in_act, in_act_v, in_wgt, in_wgt_v, out_rdy,
    input  in_act_rdy, in_wgt_rdy, out, out_v
  );
  modport slave (
    input  in_act, in_act_v, in_wgt, in_wgt_v, out_rdy,
    output in_act_rdy, in_wgt_rdy, out, out_v
  );
endinterface

// File: rtl/mvau_stream_hs.sv
// mvau_stream_hs: streaming-weight MVAU; activation vector buffered once and reused across all neuron folds
module mvau_stream_hs #(
  parameter int SIMD   = 2,
  parameter int PE     = 2,
  parameter int MW     = 8,
  parameter int MH     = 4,
  parameter int TA     = 4,
  parameter int TW     = 4,
  parameter int TACC   = 16,
  parameter int SIGNED = 1
) (
  input logic             clk,
  input logic             rst,
  mvau_stream_hs_if.slave bus_io
);
  localparam int SF  = MW / SIMD;
  localparam int NF  = MH / PE;
  localparam int SFW = SF > 1 ? $clog2(SF) : 1;
  localparam int NFW = NF > 1 ? $clog2(NF) : 1;
  logic [SFW-1:0]     sf_q, sf_d;
  logic [NFW-1:0]     nf_q, nf_d;
  logic [TACC-1:0]    acc_q [PE];
  logic [TACC-1:0]    acc_d [PE];
  logic [TACC-1:0]    sum [PE];
  logic [PE*TACC-1:0] out_q, out_d;
  logic               out_v_q, out_v_d;
  logic [SIMD*TA-1:0] act_buf [SF];
  logic [SIMD*TA-1:0] act;
  logic [TA-1:0]      a;
  logic [TW-1:0]      w;
  logic [TACC-1:0]    ae, we;
  logic               last, act_ok, out_ok, fire;
  assign last   = sf_q == SFW'(SF - 1);
  assign act_ok = nf_q != '0 || bus_io.in_act_v;
  // only the closing beat of a fold needs room in the output register
  assign out_ok = !last || !out_v_q || bus_io.out_rdy;
  assign fire   = bus_io.in_wgt_v && act_ok && out_ok;
  assign bus_io.in_wgt_rdy = act_ok && out_ok;
  assign bus_io.in_act_rdy = nf_q == '0 && bus_io.in_wgt_v && out_ok;
  assign bus_io.out        = out_q;
  assign bus_io.out_v      = out_v_q;
  assign act = nf_q == '0 ? bus_io.in_act : act_buf[sf_q];
  always_comb begin
    a  = '0;
    w  = '0;
    ae = '0;
    we = '0;
    for (int p = 0; p < PE; p++) begin
      sum[p] = '0;
      for (int s = 0; s < SIMD; s++) begin
        a  = act[s*TA +: TA];
        w  = bus_io.in_wgt[(p*SIMD+s)*TW +: TW];
        ae = SIGNED != 0 ? TACC'($signed(a)) : TACC'(a);
        we = SIGNED != 0 ? TACC'($signed(w)) : TACC'(w);
        sum[p] = sum[p] + ae * we;
      end
    end
  end
  always_comb begin
    sf_d    = fire ? (last ? '0 : sf_q + 1'b1) : sf_q;
    nf_d    = fire && last ? (nf_q == NFW'(NF - 1) ? '0 : nf_q + 1'b1) : nf_q;
    out_v_d = fire && last ? 1'b1 : (bus_io.out_rdy ? 1'b0 : out_v_q);
    out_d   = out_q;
    for (int p = 0; p < PE; p++) begin
      acc_d[p] = fire ? (sf_q == '0 ? sum[p] : acc_q[p] + sum[p]) : acc_q[p];
      if (fire && last) out_d[p*TACC +: TACC] = acc_d[p];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sf_q    <= '0;
      nf_q    <= '0;
      acc_q   <= '{default: '0};
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      sf_q    <= sf_d;
      nf_q    <= nf_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
    end
  end
  always_ff @(posedge clk)
    if (fire && nf_q == '0) act_buf[sf_q] <= bus_io.in_act;
endmodule
